// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

    localparam int DATA_W = 8;
    localparam int NREGS  = 4;
    localparam int IDX_W  = $clog2(NREGS);
    localparam int CNT_W  = 8;

    // Command kinds; encoding 2'b11 is reserved and handled like READ.
    typedef enum logic [1:0] {
        CMD_LOAD = 2'b00,
        CMD_EXEC = 2'b01,
        CMD_READ = 2'b10
    } cmd_kind_e;

    // ALU opcodes understood by the attached logic ALU.
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_NOR  = 2'b11;

    // Sequencer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response valid/ready channels between host and sequencer.
interface alu_cmd_sequencer_if;
    import alu_seq_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_kind;
    logic [1:0]        cmd_op;
    logic [IDX_W-1:0]  cmd_src_a;
    logic [IDX_W-1:0]  cmd_src_b;
    logic [IDX_W-1:0]  cmd_dst;
    logic [DATA_W-1:0] cmd_imm;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    // Host side: issues commands, consumes responses.
    modport master (
        output cmd_valid, cmd_kind, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_imm,
        input  cmd_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready
    );

    // Sequencer side: accepts commands, produces responses.
    modport slave (
        input  cmd_valid, cmd_kind, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_imm,
        output cmd_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_seq_regfile.sv
// Small register file: two asynchronous read ports, one synchronous write port.
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_a_i,
    input  logic [IDX_W-1:0]  raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] mem_q [NREGS];

    // Storage: cleared on reset, one write per cycle when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer driving an external combinational logic ALU from a
// register file and returning one response per accepted command.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    alu_cmd_sequencer_if.slave bus,
    output logic [DATA_W-1:0]  alu_a_o,
    output logic [DATA_W-1:0]  alu_b_o,
    output logic [1:0]         alu_opcode_o,
    input  logic [DATA_W-1:0]  alu_result_i,
    output logic [CNT_W-1:0]   exec_count_o
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [1:0]        alu_op_q, alu_op_d;
    logic [IDX_W-1:0]  dst_q, dst_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]  exec_cnt_q, exec_cnt_d;

    logic              cmd_ready_s;
    logic              cmd_accept_s;
    logic              rf_we_s;
    logic [IDX_W-1:0]  rf_waddr_s;
    logic [DATA_W-1:0] rf_wdata_s;
    logic [DATA_W-1:0] rf_rd_a_s;
    logic [DATA_W-1:0] rf_rd_b_s;

    // Operands are read combinationally at accept time, so src==dst sees the old value.
    alu_seq_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (rf_we_s),
        .waddr_i   (rf_waddr_s),
        .wdata_i   (rf_wdata_s),
        .raddr_a_i (bus.cmd_src_a),
        .raddr_b_i (bus.cmd_src_b),
        .rdata_a_o (rf_rd_a_s),
        .rdata_b_o (rf_rd_b_s)
    );

    // Ready is gated by rst_n so it reads 0 throughout reset.
    assign cmd_ready_s  = (state_q == ST_IDLE) && rst_n;
    assign cmd_accept_s = bus.cmd_valid && cmd_ready_s;

    // Next-state, register-file write and datapath register updates.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        dst_d      = dst_q;
        rsp_data_d = rsp_data_q;
        exec_cnt_d = exec_cnt_q;
        rf_we_s    = 1'b0;
        rf_waddr_s = bus.cmd_dst;
        rf_wdata_s = bus.cmd_imm;
        case (state_q)
            ST_IDLE: begin
                if (cmd_accept_s) begin
                    case (bus.cmd_kind)
                        CMD_LOAD: begin
                            rf_we_s    = 1'b1;
                            rf_waddr_s = bus.cmd_dst;
                            rf_wdata_s = bus.cmd_imm;
                            rsp_data_d = bus.cmd_imm;
                            state_d    = ST_RESP;
                        end
                        CMD_EXEC: begin
                            alu_a_d  = rf_rd_a_s;
                            alu_b_d  = rf_rd_b_s;
                            alu_op_d = bus.cmd_op;
                            dst_d    = bus.cmd_dst;
                            state_d  = ST_ISSUE;
                        end
                        default: begin
                            rsp_data_d = rf_rd_a_s;
                            state_d    = ST_RESP;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                rf_we_s    = 1'b1;
                rf_waddr_s = dst_q;
                rf_wdata_s = alu_result_i;
                rsp_data_d = alu_result_i;
                exec_cnt_d = exec_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            alu_a_q    <= {DATA_W{1'b0}};
            alu_b_q    <= {DATA_W{1'b0}};
            alu_op_q   <= 2'b00;
            dst_q      <= {IDX_W{1'b0}};
            rsp_data_q <= {DATA_W{1'b0}};
            exec_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            dst_q      <= dst_d;
            rsp_data_q <= rsp_data_d;
            exec_cnt_q <= exec_cnt_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_s;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign alu_a_o       = alu_a_q;
    assign alu_b_o       = alu_b_q;
    assign alu_opcode_o  = alu_op_q;
    assign exec_count_o  = exec_cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural logic ALU.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_opcode;
    logic [7:0] alu_result;
    logic [7:0] exec_count;

    int n_tests = 0;
    int n_fail  = 0;

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_opcode_o (alu_opcode),
        .alu_result_i (alu_result),
        .exec_count_o (exec_count)
    );

    // The logic ALU that sits beside the sequencer in the parent.
    always_comb begin
        case (alu_opcode)
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_NAND: alu_result = ~(alu_a & alu_b);
            default: alu_result = ~(alu_a | alu_b);
        endcase
    end

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command starting #1 after a clock edge, check latency and
    // response, optionally stall the response for 'hold' cycles, then consume it.
    task automatic do_cmd(input string tag, input logic [1:0] kind, input logic [1:0] op,
                          input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] dst,
                          input logic [7:0] imm, input logic [7:0] exp, input int hold);
        logic [7:0] cnt0;
        logic [7:0] cnt_exp;
        cnt0          = exec_count;
        cnt_exp       = (kind == CMD_EXEC) ? cnt0 + 8'd1 : cnt0;
        bus.cmd_kind  = kind;
        bus.cmd_op    = op;
        bus.cmd_src_a = sa;
        bus.cmd_src_b = sb;
        bus.cmd_dst   = dst;
        bus.cmd_imm   = imm;
        bus.cmd_valid = 1'b1;
        chk({tag, "_ready_idle"}, bus.cmd_ready, 1'b1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        if (kind == CMD_EXEC) begin
            chk({tag, "_issue_rsp_valid"}, bus.rsp_valid, 1'b0);
            chk({tag, "_issue_ready"}, bus.cmd_ready, 1'b0);
            chk({tag, "_issue_opcode"}, alu_opcode, op);
            @(posedge clk); #1;
        end
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 1'b1);
        chk({tag, "_rsp_data"}, bus.rsp_data, exp);
        chk({tag, "_count"}, exec_count, cnt_exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, bus.rsp_valid, 1'b1);
            chk({tag, "_hold_data"}, bus.rsp_data, exp);
            chk({tag, "_hold_ready"}, bus.cmd_ready, 1'b0);
            chk({tag, "_hold_count"}, exec_count, cnt_exp);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk({tag, "_done_valid"}, bus.rsp_valid, 1'b0);
        chk({tag, "_done_ready"}, bus.cmd_ready, 1'b1);
    endtask

    int n_acc;
    int n_rsp;
    int n_busy;
    int n_overlap;
    int last_acc;

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_kind  = 2'b00;
        bus.cmd_op    = 2'b00;
        bus.cmd_src_a = 2'b00;
        bus.cmd_src_b = 2'b00;
        bus.cmd_dst   = 2'b00;
        bus.cmd_imm   = 8'h00;
        bus.rsp_ready = 1'b0;

        // Reset state.
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_data", bus.rsp_data, 8'h00);
        chk("rst_alu_a", alu_a, 8'h00);
        chk("rst_alu_b", alu_b, 8'h00);
        chk("rst_alu_opcode", alu_opcode, 2'b00);
        chk("rst_exec_count", exec_count, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", bus.cmd_ready, 1'b1);

        // Loads and reads.
        do_cmd("load_r0", CMD_LOAD, 2'b00, 2'd0, 2'd0, 2'd0, 8'hF0, 8'hF0, 0);
        do_cmd("load_r1", CMD_LOAD, 2'b00, 2'd0, 2'd0, 2'd1, 8'h3C, 8'h3C, 0);
        do_cmd("read_r1", CMD_READ, 2'b00, 2'd1, 2'd0, 2'd0, 8'h00, 8'h3C, 0);
        do_cmd("rsvd_r0", 2'b11,    2'b00, 2'd0, 2'd0, 2'd1, 8'h55, 8'hF0, 0);
        do_cmd("read_r1b", CMD_READ, 2'b00, 2'd1, 2'd0, 2'd0, 8'h00, 8'h3C, 0);

        // All four ALU ops, r0 op r1 -> r2.
        do_cmd("exec_and",  CMD_EXEC, OP_AND,  2'd0, 2'd1, 2'd2, 8'h00, 8'h30, 0);
        do_cmd("exec_or",   CMD_EXEC, OP_OR,   2'd0, 2'd1, 2'd2, 8'h00, 8'hFC, 0);
        do_cmd("exec_nand", CMD_EXEC, OP_NAND, 2'd0, 2'd1, 2'd2, 8'h00, 8'hCF, 0);
        do_cmd("exec_nor",  CMD_EXEC, OP_NOR,  2'd0, 2'd1, 2'd2, 8'h00, 8'h03, 0);
        chk("exec_count_4", exec_count, 8'd4);
        do_cmd("read_r2", CMD_READ, 2'b00, 2'd2, 2'd0, 2'd0, 8'h00, 8'h03, 0);

        // Back-to-back EXECs with valid and rsp_ready held high.
        bus.cmd_kind  = CMD_EXEC;
        bus.cmd_op    = OP_OR;
        bus.cmd_src_a = 2'd0;
        bus.cmd_src_b = 2'd1;
        bus.cmd_dst   = 2'd3;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        n_acc = 0; n_rsp = 0; n_busy = 0; n_overlap = 0; last_acc = 0;
        for (int c = 0; c < 9; c++) begin
            if (bus.cmd_ready && bus.rsp_valid) n_overlap++;
            if (!bus.cmd_ready) n_busy++;
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (n_acc > 0) chk("b2b_gap", c - last_acc, 3);
                last_acc = c;
                n_acc++;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk("b2b_rsp_data", bus.rsp_data, 8'hFC);
                n_rsp++;
            end
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        chk("b2b_accepts", n_acc, 3);
        chk("b2b_responses", n_rsp, 3);
        chk("b2b_busy_cycles", n_busy, 6);
        chk("b2b_ready_in_resp", n_overlap, 0);
        chk("b2b_exec_count", exec_count, 8'd7);
        chk("b2b_end_ready", bus.cmd_ready, 1'b1);

        // Response stalled for 5 cycles.
        do_cmd("stall_nor", CMD_EXEC, OP_NOR, 2'd0, 2'd1, 2'd3, 8'h00, 8'h03, 5);
        chk("stall_count", exec_count, 8'd8);

        // src == dst: old value read, new value written.
        do_cmd("load_r2_a5", CMD_LOAD, 2'b00, 2'd0, 2'd0, 2'd2, 8'hA5, 8'hA5, 0);
        do_cmd("exec_r2r2",  CMD_EXEC, OP_AND, 2'd2, 2'd2, 2'd2, 8'h00, 8'hA5, 0);
        do_cmd("read_r2_a5", CMD_READ, 2'b00, 2'd2, 2'd0, 2'd0, 8'h00, 8'hA5, 0);

        // Reset asserted during ISSUE.
        bus.cmd_kind  = CMD_EXEC;
        bus.cmd_op    = OP_OR;
        bus.cmd_src_a = 2'd0;
        bus.cmd_src_b = 2'd1;
        bus.cmd_dst   = 2'd3;
        bus.cmd_valid = 1'b1;
        chk("ri_ready", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        chk("ri_issue_alu_a", alu_a, 8'hF0);
        chk("ri_issue_opcode", alu_opcode, OP_OR);
        rst_n = 1'b0;
        #1;
        chk("ri_cmd_ready", bus.cmd_ready, 1'b0);
        chk("ri_rsp_valid", bus.rsp_valid, 1'b0);
        chk("ri_rsp_data", bus.rsp_data, 8'h00);
        chk("ri_alu_a", alu_a, 8'h00);
        chk("ri_alu_b", alu_b, 8'h00);
        chk("ri_alu_opcode", alu_opcode, 2'b00);
        chk("ri_exec_count", exec_count, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_cmd("ri_read_r0", CMD_READ, 2'b00, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 0);
        do_cmd("ri_read_r1", CMD_READ, 2'b00, 2'd1, 2'd0, 2'd0, 8'h00, 8'h00, 0);
        do_cmd("ri_read_r2", CMD_READ, 2'b00, 2'd2, 2'd0, 2'd0, 8'h00, 8'h00, 0);
        do_cmd("ri_read_r3", CMD_READ, 2'b00, 2'd3, 2'd0, 2'd0, 8'h00, 8'h00, 0);
        chk("ri_count_after", exec_count, 8'h00);

        // exec_count wrap after 256 EXECs (all registers are zero, AND gives 0).
        for (int i = 0; i < 255; i++) begin
            do_cmd("wrap_exec", CMD_EXEC, OP_AND, 2'd0, 2'd1, 2'd0, 8'h00, 8'h00, 0);
        end
        chk("wrap_count_ff", exec_count, 8'hFF);
        do_cmd("wrap_last", CMD_EXEC, OP_NOR, 2'd0, 2'd1, 2'd1, 8'h00, 8'hFF, 0);
        chk("wrap_count_00", exec_count, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
